// File: rtl/adder_pkg.sv
// Shared widths and segment geometry for the pipelined mantissa adder.
package adder_pkg;

  // Default mantissa/product sum width shared with the multiplier datapath.
  localparam int MANT_SUM_W      = 36;
  localparam int MANT_SUM_STAGES = 3;

  // Width of segment k: ceil(width/stages) bits, the last segment takes the remainder.
  function automatic int seg_width(input int width, input int stages, input int k);
    int seg;
    seg = (width + stages - 1) / stages;
    return (k == stages - 1) ? (width - (stages - 1) * seg) : seg;
  endfunction

  // Bit position of the least significant bit of segment k.
  function automatic int seg_lsb(input int width, input int stages, input int k);
    int seg;
    seg = (width + stages - 1) / stages;
    return k * seg;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Registered carry-chained segment adder: one slice of the wide sum per clock.
module adder_seg #(
  parameter int SEG_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             c_in,
  output logic [SEG_W-1:0] s_seg,
  output logic             c_out
);

  logic [SEG_W:0] total;

  assign total = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};

  // Capture the slice sum and its carry whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '0;
      c_out <= 1'b0;
    end else if (en) begin
      s_seg <= total[SEG_W-1:0];
      c_out <= total[SEG_W];
    end
  end

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor with valid/ready backpressure.
// Segment k of the sum is produced in stage k; operands ride ahead in skew
// registers and finished segments ride behind in de-skew registers so that
// the last stage presents a complete, aligned result.
module pipelined_adder_sub
  import adder_pkg::*;
#(
  parameter int WIDTH  = MANT_SUM_W,
  parameter int STAGES = MANT_SUM_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Mask of the last segment, used to merge it with the de-skewed low part.
  localparam int              LAST_W    = seg_width(WIDTH, STAGES, STAGES - 1);
  localparam int              LAST_LSB  = seg_lsb(WIDTH, STAGES, STAGES - 1);
  localparam logic [WIDTH-1:0] LAST_MASK = ((ONE << LAST_W) - ONE) << LAST_LSB;

  logic              stall;
  logic              advance;
  logic [WIDTH-1:0]  bx_in;
  logic              c0;
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] carry;
  logic [WIDTH-1:0]  seg_sum;

  // Per-stage operand and partial-sum words entering each stage register.
  logic [WIDTH-1:0]  a_src       [STAGES];
  logic [WIDTH-1:0]  bx_src      [STAGES];
  logic [WIDTH-1:0]  sum_src     [STAGES];
  logic              c_src       [STAGES];
  logic [WIDTH-1:0]  a_skew_reg  [STAGES];
  logic [WIDTH-1:0]  bx_skew_reg [STAGES];
  logic [WIDTH-1:0]  sum_dsk_reg [STAGES];

  // Subtraction is a + ~b + 1, so the carry-in is forced when sub is set.
  assign bx_in = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  // The whole pipe freezes while a result waits; in_ready follows out_ready combinationally.
  assign out_valid = valid_reg[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign advance   = !stall;
  assign in_ready  = !stall;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int W_K = seg_width(WIDTH, STAGES, gi);
    localparam int LSB = seg_lsb(WIDTH, STAGES, gi);

    if (gi == 0) begin : g_first
      assign a_src[gi]   = a;
      assign bx_src[gi]  = bx_in;
      assign c_src[gi]   = c0;
      assign sum_src[gi] = '0;
    end else begin : g_rest
      localparam int               PREV_W    = seg_width(WIDTH, STAGES, gi - 1);
      localparam int               PREV_LSB  = seg_lsb(WIDTH, STAGES, gi - 1);
      localparam logic [WIDTH-1:0] PREV_MASK = ((ONE << PREV_W) - ONE) << PREV_LSB;

      assign a_src[gi]   = a_skew_reg[gi-1];
      assign bx_src[gi]  = bx_skew_reg[gi-1];
      assign c_src[gi]   = carry[gi-1];
      // Fold the segment finished by the previous stage into the de-skew word.
      assign sum_src[gi] = (sum_dsk_reg[gi-1] & ~PREV_MASK) | (seg_sum & PREV_MASK);
    end

    adder_seg #(
      .SEG_W(W_K)
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a_seg (a_src[gi][LSB +: W_K]),
      .b_seg (bx_src[gi][LSB +: W_K]),
      .c_in  (c_src[gi]),
      .s_seg (seg_sum[LSB +: W_K]),
      .c_out (carry[gi])
    );
  end

  // Shift valid bits, skewed operands and de-skewed partial sums one stage per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_skew_reg[k]  <= '0;
        bx_skew_reg[k] <= '0;
        sum_dsk_reg[k] <= '0;
      end
    end else if (advance) begin
      valid_reg[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_skew_reg[k]  <= a_src[k];
        bx_skew_reg[k] <= bx_src[k];
        sum_dsk_reg[k] <= sum_src[k];
      end
    end
  end

  // Last stage: merge its own segment with the de-skewed lower segments.
  assign sum  = (sum_dsk_reg[STAGES-1] & ~LAST_MASK) | (seg_sum & LAST_MASK);
  assign cout = carry[STAGES-1];
  // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
  assign ovf  = cout ^ a_skew_reg[STAGES-1][WIDTH-1] ^ bx_skew_reg[STAGES-1][WIDTH-1]
              ^ sum[WIDTH-1];

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: directed corners, backpressure stream,
// mid-flight reset and a sweep over several (WIDTH, STAGES) configurations.
module tb_pipelined_adder_sub;

  localparam int NDUT = 5;
  localparam int WS [NDUT] = '{36, 36, 36, 24, 53};
  localparam int SS [NDUT] = '{3, 1, 5, 24, 4};

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NDUT-1:0]            in_valid_v = '0;
  logic [NDUT-1:0]            in_ready_v;
  logic [NDUT-1:0]            out_valid_v;
  logic [NDUT-1:0]            out_ready_v = '0;
  logic [NDUT-1:0]            cin_v = '0;
  logic [NDUT-1:0]            sub_v = '0;
  logic [NDUT-1:0]            cout_v;
  logic [NDUT-1:0]            ovf_v;
  logic [NDUT-1:0][63:0]      a_v = '0;
  logic [NDUT-1:0][63:0]      b_v = '0;
  logic [NDUT-1:0][63:0]      sum_v;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int W = WS[gi];
    logic [W-1:0] sum_w;

    pipelined_adder_sub #(
      .WIDTH  (W),
      .STAGES (SS[gi])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .a         (a_v[gi][W-1:0]),
      .b         (b_v[gi][W-1:0]),
      .cin       (cin_v[gi]),
      .sub       (sub_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .sum       (sum_w),
      .cout      (cout_v[gi]),
      .ovf       (ovf_v[gi])
    );

    assign sum_v[gi] = {{(64-W){1'b0}}, sum_w};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb);
    longint m;
    longint ua;
    longint ub;
    longint sa;
    longint sbv;
    longint u;
    longint t;
    res_t   r;
    m   = longint'(1) << w;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = av[w-1] ? ua - m : ua;
    sbv = bv[w-1] ? ub - m : ub;
    if (sb) begin
      u = ua - ub + m;
      t = sa - sbv;
    end else begin
      u = ua + ub + longint'(ci);
      t = sa + sbv + longint'(ci);
    end
    r.s = 64'(u) & 64'(m - 1);
    r.c = (u >= m);
    r.o = (t < -(m / 2)) || (t >= (m / 2));
    return r;
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  // One beat into an idle pipe: checks latency and the result.
  task automatic single_beat(input int d, input logic [63:0] av, input logic [63:0] bv,
                             input logic ci, input logic sb, input res_t e, input string tag);
    int lat;
    a_v[d] = av;
    b_v[d] = bv;
    cin_v[d] = ci;
    sub_v[d] = sb;
    out_ready_v[d] = 1'b1;
    in_valid_v[d] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_v[d]), 64'd1);
    @(posedge clk);
    #1;
    in_valid_v[d] = 1'b0;
    lat = 1;
    while (!out_valid_v[d] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(SS[d]));
    chk({tag, "_sum"}, sum_v[d], e.s);
    chk({tag, "_cout"}, 64'(cout_v[d]), 64'(e.c));
    chk({tag, "_ovf"}, 64'(ovf_v[d]), 64'(e.o));
    $display("beat dut%0d %s a=%0h b=%0h cin=%0b sub=%0b -> sum=%0h cout=%0b ovf=%0b lat=%0d",
             d, tag, av, bv, ci, sb, sum_v[d], cout_v[d], ovf_v[d], lat);
    @(posedge clk);
    #1;
  endtask

  // Back-to-back random beats with out_ready held low for cycles 5..8.
  task automatic run_stream(input int d, input int n);
    res_t        q[$];
    res_t        e;
    res_t        got_r;
    int          sent;
    int          got;
    int          cyc;
    int          extra;
    logic        accepted;
    logic        was_stalled;
    logic [63:0] held_sum;
    sent = 0;
    got = 0;
    cyc = 0;
    extra = 0;
    was_stalled = 1'b0;
    held_sum = '0;
    a_v[d] = rnd(WS[d]);
    b_v[d] = rnd(WS[d]);
    cin_v[d] = 1'($urandom);
    sub_v[d] = 1'($urandom);
    while (got < n && cyc < 300) begin
      out_ready_v[d] = !(cyc >= 5 && cyc <= 8);
      in_valid_v[d] = (sent < n);
      #1;
      if (out_valid_v[d] && !out_ready_v[d]) begin
        chk("stall_in_ready", 64'(in_ready_v[d]), 64'd0);
        if (was_stalled) chk("stall_sum_stable", sum_v[d], held_sum);
        held_sum = sum_v[d];
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (out_valid_v[d] && out_ready_v[d]) begin
        if (q.size() == 0) begin
          chk("stream_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          got_r.s = sum_v[d];
          got_r.c = cout_v[d];
          got_r.o = ovf_v[d];
          chk("stream_sum", got_r.s, e.s);
          chk("stream_cout", 64'(got_r.c), 64'(e.c));
          chk("stream_ovf", 64'(got_r.o), 64'(e.o));
          $display("stream dut%0d out#%0d sum=%0h cout=%0b ovf=%0b", d, got, got_r.s, got_r.c,
                   got_r.o);
        end
        got++;
      end
      accepted = in_valid_v[d] && in_ready_v[d];
      if (accepted) begin
        q.push_back(model(WS[d], a_v[d], b_v[d], cin_v[d], sub_v[d]));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (accepted) begin
        a_v[d] = rnd(WS[d]);
        b_v[d] = rnd(WS[d]);
        cin_v[d] = 1'($urandom);
        sub_v[d] = 1'($urandom);
      end
    end
    chk("stream_received", 64'(got), 64'(n));
    chk("stream_sent", 64'(sent), 64'(n));
    in_valid_v[d] = 1'b0;
    out_ready_v[d] = 1'b1;
    for (int i = 0; i < 2 * SS[d] + 2; i++) begin
      #1;
      if (out_valid_v[d]) extra++;
      @(posedge clk);
      #1;
    end
    chk("stream_no_duplicate", 64'(extra), 64'd0);
  endtask

  initial begin
    res_t e;
    int   stale;
    int   wait_cyc;
    logic [63:0] av;
    logic [63:0] bv;
    logic        ci;
    logic        sb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid_v), 64'd0);
    chk("reset_in_ready", 64'(in_ready_v), {{(64-NDUT){1'b0}}, {NDUT{1'b1}}});
    chk("reset_sum", sum_v[0], 64'd0);
    chk("reset_cout", 64'(cout_v[0]), 64'd0);
    chk("reset_ovf", 64'(ovf_v[0]), 64'd0);
    @(posedge clk);
    #1;

    // Directed corners on the default 36-bit, 3-stage configuration.
    e = '{s: 64'h0_0000_1000, c: 1'b0, o: 1'b0};
    single_beat(0, 64'h0_0000_0FFF, 64'h1, 1'b0, 1'b0, e, "seg_carry");
    e = '{s: 64'h0, c: 1'b1, o: 1'b0};
    single_beat(0, 64'hF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, e, "full_ripple");
    e = '{s: 64'hF_FFFF_FFFF, c: 1'b0, o: 1'b0};
    single_beat(0, 64'h0, 64'h1, 1'b0, 1'b1, e, "sub_borrow");
    e = '{s: 64'h7_FFFF_FFFF, c: 1'b1, o: 1'b1};
    single_beat(0, 64'h8_0000_0000, 64'h1, 1'b0, 1'b1, e, "sub_ovf");
    e = '{s: 64'hF_FFFF_FFFF, c: 1'b1, o: 1'b0};
    single_beat(0, 64'hF_FFFF_FFFF, 64'hF_FFFF_FFFF, 1'b1, 1'b0, e, "ones_plus_ones");
    e = '{s: 64'h0, c: 1'b1, o: 1'b0};
    single_beat(0, 64'h5_A5A5_A5A5, 64'h5_A5A5_A5A5, 1'b0, 1'b1, e, "sub_equal");
    e = '{s: 64'h2, c: 1'b1, o: 1'b0};
    single_beat(0, 64'h5, 64'h3, 1'b1, 1'b1, e, "sub_ignores_cin");

    // Reset with two beats in flight, the first parked at the output.
    out_ready_v[0] = 1'b0;
    a_v[0] = 64'h1;
    b_v[0] = 64'h2;
    cin_v[0] = 1'b0;
    sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    a_v[0] = 64'h3;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    wait_cyc = 0;
    while (!out_valid_v[0] && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    chk("pre_reset_out_valid", 64'(out_valid_v[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("async_reset_sum", sum_v[0], 64'd0);
    $display("reset asserted mid-flight: out_valid=%0b", out_valid_v[0]);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready_v[0] = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid_v[0]) stale++;
      @(posedge clk);
      #1;
    end
    chk("no_stale_after_reset", 64'(stale), 64'd0);
    e = '{s: 64'h0_0000_1234, c: 1'b0, o: 1'b0};
    single_beat(0, 64'h0_0000_1000, 64'h234, 1'b0, 1'b0, e, "post_reset");

    // Stream with backpressure plus random latency/result checks for every configuration.
    for (int d = 0; d < NDUT; d++) begin
      $display("config dut%0d WIDTH=%0d STAGES=%0d", d, WS[d], SS[d]);
      run_stream(d, 10);
      for (int i = 0; i < 4; i++) begin
        av = rnd(WS[d]);
        bv = rnd(WS[d]);
        ci = 1'($urandom);
        sb = 1'($urandom);
        e = model(WS[d], av, bv, ci, sb);
        single_beat(d, av, bv, ci, sb, e, "sweep");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
